flowing_light_ctrl: RTL
=======================

// Module: flowing_light_ctrl
// PURPOSE
//  Sequencer for the board LED bar: owns step-rate prescaler, direction and mode FSM.
//  Drives a one-hot LED pattern from host commands on a valid/ready port.
//  Sits between the host/button decoder and the LED pins; replaces free-running shifters.
// PARAMETERS
//  N_LED    4         LED count; pattern width; >=2
//  DIV_W    24        prescaler/divisor width
//  DEF_DIV  24'hFFFFFF  divisor after reset; step period = DEF_DIV+1 clk cycles
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      reset; asynchronous, active-low (0 = reset)
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command accepted when cmd_valid & cmd_ready
//  cmd_op     in   3      opcode (see BEHAVIOUR)
//  cmd_arg    in   DIV_W  operand for SET_DIV / SET_BRIGHT
//  led        out  N_LED  LED drive, 1 = on
//  step       out  1      1-cycle pulse when pattern advanced
// BEHAVIOUR
//  Reset (async assert, sync deassert): led=1 (bit0), state=STOP, dir=LEFT, div=DEF_DIV,
//   cnt=0, step=0, cmd_ready=1, bright=15.
//  Handshake: accept on valid&ready; command registered, applied next cycle (APPLY);
//   cmd_ready=0 during APPLY only, so max 1 cmd per 2 cycles. No effect while cmd_valid & !cmd_ready.
//  Opcodes: 0 STOP, 1 RUN_L, 2 RUN_R, 3 BOUNCE, 4 SET_DIV(arg), 5 STEP, 6 SET_BRIGHT(arg[3:0]), 7 reserved (ignored).
//  States: STOP, RUN (dir fixed), BOUNCE (dir reverses at ends).
//   STOP   -> RUN on RUN_L/RUN_R (sets dir); -> BOUNCE on BOUNCE.
//   RUN/BOUNCE -> STOP on STOP; RUN_L/RUN_R/BOUNCE switch mode in place; pattern kept.
//  Prescaler: cnt counts 0..div; tick when cnt==div, then cnt=0. div=0 -> tick every cycle.
//   cnt frozen at 0 in STOP. RUN_*/BOUNCE/SET_DIV apply clears cnt (first tick div+1 cycles later).
//  Advance on tick (RUN/BOUNCE) or STEP apply (STOP only; STEP ignored in RUN/BOUNCE):
//   LEFT  rotates toward MSB, MSB wraps to bit0; RIGHT toward LSB, bit0 wraps to MSB.
//   BOUNCE: at MSB with dir LEFT -> dir=RIGHT and move to MSB-1 same tick; mirror at bit0.
//  Pattern always one-hot; if ever 0 (upset) reload 1 on next clk.
//  step=1 in the cycle after each advance (registered), else 0.
//  Apply cycle vs tick in same cycle: command wins, tick discarded.
//  SET_DIV mid-run: new div used immediately; mode, dir, pattern unchanged.
//  Reset mid-operation: all state to reset values immediately; pending command dropped.
// CONFIGURATION
//  LED_PWM_EN defined: 4-bit free-running pwm_cnt; led = pattern & {N_LED{pwm_cnt <= bright}};
//   SET_BRIGHT loads bright=arg[3:0]; bright=15 -> full on, 0 -> 1/16 duty.
//  LED_PWM_EN undefined: led = pattern; opcode 6 accepted and ignored; no pwm logic.
// STRUCTURE
//  flowing_light_pkg: opcode localparams (OP_STOP..OP_SET_BRIGHT), state and dir encodings.
//  Sub-module flowing_light_tick: prescaler (div, clear, enable -> tick); rest in top.
// TESTING
//  1 Reset, no cmds 100 cycles -> led=0001, step never 1, cmd_ready=1.
//  2 SET_DIV 2, RUN_L -> led 0010,0100,1000,0001 every 3 cycles; step pulse each change.
//  3 RUN_R div=0 -> led 1000,0100,0010,0001,1000 on consecutive cycles.
//  4 BOUNCE div=0 from 0001 -> 0010,0100,1000,0100,0010,0001,0010.
//  5 STOP then STEP x2 (dir LEFT, from 0100) -> 1000, 0001; STEP during RUN -> no extra advance.
//  6 rst low mid-RUN with cmd_valid high -> led=0001 same cycle, state STOP, cmd dropped;
//    LED_PWM_EN build: SET_BRIGHT 3 -> each led bit on 4 of 16 cycles.

Source files
------------

// File: rtl/flowing_light_pkg.sv
// Shared opcodes and state/direction encodings for the LED bar sequencer.
// Optional PWM dimming in flowing_light_ctrl is enabled by defining LED_PWM_EN.
package flowing_light_pkg;

   localparam logic [2:0] OP_STOP       = 3'd0;
   localparam logic [2:0] OP_RUN_L      = 3'd1;
   localparam logic [2:0] OP_RUN_R      = 3'd2;
   localparam logic [2:0] OP_BOUNCE     = 3'd3;
   localparam logic [2:0] OP_SET_DIV    = 3'd4;
   localparam logic [2:0] OP_STEP       = 3'd5;
   localparam logic [2:0] OP_SET_BRIGHT = 3'd6;

   typedef enum logic [1:0] {
      ST_STOP   = 2'd0,
      ST_RUN    = 2'd1,
      ST_BOUNCE = 2'd2
   } state_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

endpackage

// File: rtl/flowing_light_tick.sv
// Step-rate prescaler: counts 0..div while enabled and flags the terminal count.
module flowing_light_tick #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   input  logic             clear,
   input  logic             enable,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = enable && (cnt == div);

   // Held at zero while disabled so a restart always begins a full period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear || !enable || (cnt == div)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/flowing_light_ctrl.sv
// LED bar sequencer: host commands on a valid/ready port drive a one-hot pattern.
// Define LED_PWM_EN to add 16-level brightness dimming via SET_BRIGHT.
module flowing_light_ctrl
   import flowing_light_pkg::*;
#(
   parameter int               N_LED   = 4,
   parameter int               DIV_W   = 24,
   parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(24'hFFFFFF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [DIV_W-1:0] cmd_arg,
   output logic [N_LED-1:0] led,
   output logic             step
);

   localparam logic [N_LED-1:0] ONE = N_LED'(1);

   state_t           state, state_nxt;
   dir_t             dir, dir_nxt;
   logic [N_LED-1:0] pattern, pattern_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic             apply;
   logic [2:0]       op;
   logic [DIV_W-1:0] arg;
   logic             accept, tick, clear, advance;

   function automatic logic [N_LED-1:0] rot_left(input logic [N_LED-1:0] p);
      return {p[N_LED-2:0], p[N_LED-1]};
   endfunction

   function automatic logic [N_LED-1:0] rot_right(input logic [N_LED-1:0] p);
      return {p[0], p[N_LED-1:1]};
   endfunction

   assign cmd_ready = !apply;
   assign accept    = cmd_valid && cmd_ready;

   flowing_light_tick #(.DIV_W(DIV_W)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .div    (div),
      .clear  (clear),
      .enable (state != ST_STOP),
      .tick   (tick)
   );

   // A command being applied takes priority over a coincident prescaler tick.
   always_comb begin
      state_nxt   = state;
      dir_nxt     = dir;
      div_nxt     = div;
      pattern_nxt = pattern;
      clear       = 1'b0;
      advance     = 1'b0;
      if (apply) begin
         case (op)
            OP_STOP:       state_nxt = ST_STOP;
            OP_RUN_L:      begin state_nxt = ST_RUN; dir_nxt = DIR_LEFT;  clear = 1'b1; end
            OP_RUN_R:      begin state_nxt = ST_RUN; dir_nxt = DIR_RIGHT; clear = 1'b1; end
            OP_BOUNCE:     begin state_nxt = ST_BOUNCE; clear = 1'b1; end
            OP_SET_DIV:    begin div_nxt = arg; clear = 1'b1; end
            OP_STEP:       advance = (state == ST_STOP);
            OP_SET_BRIGHT: ;
            default:       ;
         endcase
      end else begin
         advance = tick;
      end

      if (advance) begin
         if (state == ST_BOUNCE && dir == DIR_LEFT && pattern[N_LED-1]) begin
            dir_nxt     = DIR_RIGHT;
            pattern_nxt = rot_right(pattern);
         end else if (state == ST_BOUNCE && dir == DIR_RIGHT && pattern[0]) begin
            dir_nxt     = DIR_LEFT;
            pattern_nxt = rot_left(pattern);
         end else if (dir == DIR_LEFT) begin
            pattern_nxt = rot_left(pattern);
         end else begin
            pattern_nxt = rot_right(pattern);
         end
      end

      // Recover from an upset that cleared the pattern.
      if (pattern == '0) begin
         pattern_nxt = ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_STOP;
         dir     <= DIR_LEFT;
         pattern <= ONE;
         div     <= DEF_DIV;
         apply   <= 1'b0;
         op      <= OP_STOP;
         arg     <= '0;
         step    <= 1'b0;
      end else begin
         state   <= state_nxt;
         dir     <= dir_nxt;
         pattern <= pattern_nxt;
         div     <= div_nxt;
         apply   <= accept;
         step    <= advance;
         if (accept) begin
            op  <= cmd_op;
            arg <= cmd_arg;
         end
      end
   end

`ifdef LED_PWM_EN
   logic [3:0] pwm_cnt;
   logic [3:0] bright;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_cnt <= '0;
         bright  <= 4'd15;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (apply && op == OP_SET_BRIGHT) begin
            bright <= arg[3:0];
         end
      end
   end

   assign led = pattern & {N_LED{pwm_cnt <= bright}};
`else
   assign led = pattern;
`endif

endmodule
